// File: rtl/md_sched.sv
// Multiply/divide sequencer for the E stage: captures an MD result at issue, holds it for a
// fixed latency, then commits it to HI/LO while raising stall_md for MD-class instructions in D.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_E,
  input  logic [2:0]  i_md_op_E,
  input  logic [31:0] i_rs_E,
  input  logic [31:0] i_rt_E,
  input  logic        i_md_use_D,
  output logic        o_busy,
  output logic        o_stall_md,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [31:0]     r_pend_hi;
  logic [31:0]     r_pend_lo;
  logic            r_pend_wr;

  logic            w_is_mul;
  logic            w_is_div;
  logic            w_is_signed;
  logic [63:0]     w_mul_a;
  logic [63:0]     w_mul_b;
  logic [63:0]     w_prod;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [31:0]     w_mag_a;
  logic [31:0]     w_mag_b;
  logic [31:0]     w_div_b;
  logic [31:0]     w_q_mag;
  logic [31:0]     w_r_mag;
  logic [31:0]     w_quot;
  logic [31:0]     w_rem;
  logic            w_div_zero;

  assign w_is_mul    = (i_md_op_E == OP_MULT) || (i_md_op_E == OP_MULTU);
  assign w_is_div    = (i_md_op_E == OP_DIV)  || (i_md_op_E == OP_DIVU);
  assign w_is_signed = (i_md_op_E == OP_MULT) || (i_md_op_E == OP_DIV);

  // One 64-bit multiplier serves both flavours: operands are sign- or zero-extended first,
  // and the low 64 bits of the product are exact in either case.
  assign w_mul_a = w_is_signed ? {{32{i_rs_E[31]}}, i_rs_E} : {32'd0, i_rs_E};
  assign w_mul_b = w_is_signed ? {{32{i_rt_E[31]}}, i_rt_E} : {32'd0, i_rt_E};
  assign w_prod  = w_mul_a * w_mul_b;

  // Division on magnitudes, then signs restored: quotient truncates toward zero and the
  // remainder follows the dividend.
  assign w_neg_a    = w_is_signed & i_rs_E[31];
  assign w_neg_b    = w_is_signed & i_rt_E[31];
  assign w_mag_a    = w_neg_a ? (32'd0 - i_rs_E) : i_rs_E;
  assign w_mag_b    = w_neg_b ? (32'd0 - i_rt_E) : i_rt_E;
  assign w_div_zero = (i_rt_E == 32'd0);
  assign w_div_b    = w_div_zero ? 32'd1 : w_mag_b;
  assign w_q_mag    = w_mag_a / w_div_b;
  assign w_r_mag    = w_mag_a % w_div_b;
  assign w_quot     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem      = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start_E) begin
            if (w_is_mul) begin
              r_pend_hi <= w_prod[63:32];
              r_pend_lo <= w_prod[31:0];
              r_pend_wr <= 1'b1;
              r_cnt     <= CW'(MULT_CYCLES);
              r_state   <= ST_MUL;
              r_busy    <= 1'b1;
            end else if (w_is_div) begin
              r_pend_hi <= w_rem;
              r_pend_lo <= w_quot;
              r_pend_wr <= ~w_div_zero;
              r_cnt     <= CW'(DIV_CYCLES);
              r_state   <= ST_DIV;
              r_busy    <= 1'b1;
            end else if (i_md_op_E == OP_MTHI) begin
              r_hi <= i_rs_E;
            end else if (i_md_op_E == OP_MTLO) begin
              r_lo <= i_rs_E;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // Any start_E seen here is deliberately ignored.
          if (r_cnt == CW'(1)) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_stall_md = i_md_use_D & (r_busy | (i_start_E & (w_is_mul | w_is_div)));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected HI/LO pairs are queued at issue and compared on the
// cycle after busy falls; occupancy, done pulse and stall_md are checked along the way.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [2:0]  md_op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .i_clk(clk), .i_reset(reset), .i_start_E(start_E), .i_md_op_E(md_op_E),
    .i_rs_E(rs_E), .i_rt_E(rt_E), .i_md_use_D(md_use_D),
    .o_busy(busy), .o_stall_md(stall_md), .o_hi(hi), .o_lo(lo), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference built on native SV arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] old);
    longint sa, sb;
    longint unsigned ua, ub;
    int ia, ib;
    case (op)
      3'd1: begin sa = longint'($signed(a)); sb = longint'($signed(b)); return 64'(sa * sb); end
      3'd2: begin ua = {32'd0, a}; ub = {32'd0, b}; return 64'(ua * ub); end
      3'd3: begin
        if (b == 32'd0) return old;
        ia = a; ib = b;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd4: begin
        if (b == 32'd0) return old;
        return {a % b, a / b};
      end
      default: return old;
    endcase
  endfunction

  task automatic push_exp(input logic [63:0] v);
    exp_q.push_back(v);
    model_hilo = v;
  endtask

  // Issue one mult/div, count busy cycles, then pop the scoreboard when the result lands.
  // inj_at >= 0 fires an illegal div start on that busy cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp, input logic use_d,
                        input int inj_at);
    int busy_n;
    int stall_n;
    int done_early;
    logic [63:0] e;
    busy_n = 0; stall_n = 0; done_early = 0;
    md_use_D = use_d;
    start_E = 1'b1; md_op_E = op; rs_E = a; rt_E = b;
    #1;
    if (stall_md === 1'b1) stall_n++;
    step();
    start_E = 1'b0; md_op_E = 3'd0;
    while (busy === 1'b1 && busy_n < 40) begin
      if (stall_md === 1'b1) stall_n++;
      if (done !== 1'b0) done_early++;
      if (busy_n == inj_at) begin
        start_E = 1'b1; md_op_E = 3'd3; rs_E = 32'h0000_0064; rt_E = 32'h0000_0003;
      end
      step();
      start_E = 1'b0; md_op_E = 3'd0;
      busy_n++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(n_exp));
    check({tag, "_done_early"}, 32'(done_early), 32'd0);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
    end
    if (use_d) begin
      check({tag, "_stall_cycles"}, 32'(stall_n), 32'(1 + n_exp));
      check({tag, "_stall_after"}, {31'd0, stall_md}, 32'd0);
    end
    step();
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    md_use_D = 1'b0;
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] v,
                         input logic use_d);
    md_use_D = use_d;
    start_E = 1'b1; md_op_E = op; rs_E = v; rt_E = 32'h0;
    #1;
    if (use_d) check({tag, "_stall"}, {31'd0, stall_md}, 32'd0);
    step();
    start_E = 1'b0; md_op_E = 3'd0;
    if (op == 3'd5) model_hilo[63:32] = v;
    if (op == 3'd6) model_hilo[31:0] = v;
    check({tag, "_hi"}, hi, model_hilo[63:32]);
    check({tag, "_lo"}, lo, model_hilo[31:0]);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_n;
    reset = 1'b1; start_E = 1'b1; md_op_E = 3'd1; rs_E = 32'h7; rt_E = 32'h9; md_use_D = 1'b0;
    model_hilo = 64'd0;
    step(); step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0; start_E = 1'b0; md_op_E = 3'd0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    push_exp({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'h0000_0007, MC, 1'b0, -1);
    push_exp({32'h0000_0001, 32'hFFFF_FFFE});
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b0, -1);
    push_exp({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, DC, 1'b0, -1);
    push_exp({32'h0000_0001, 32'h7FFF_FFFC});
    run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, DC, 1'b0, -1);

    push_exp(model(3'd1, 32'h8000_0000, 32'h8000_0000, model_hilo));
    run_op("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000, MC, 1'b1, -1);
    push_exp(model(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, model_hilo));
    run_op("div_negb", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, DC, 1'b1, -1);
    push_exp(model(3'd2, 32'hDEAD_BEEF, 32'h1234_5678, model_hilo));
    run_op("multu_rand", 3'd2, 32'hDEAD_BEEF, 32'h1234_5678, MC, 1'b0, -1);

    move_to("mthi", 3'd5, 32'h1234_5678, 1'b1);
    md_use_D = 1'b1; #1;
    check("mflo_stall", {31'd0, stall_md}, 32'd0);
    check("mflo_hi", hi, 32'h1234_5678);
    md_use_D = 1'b0;
    step();

    md_use_D = 1'b0; start_E = 1'b1; md_op_E = 3'd7; rs_E = 32'hFFFF_FFFF; rt_E = 32'h1;
    step();
    start_E = 1'b0; md_op_E = 3'd0;
    check("nop7_busy", {31'd0, busy}, 32'd0);
    check("nop7_hi", hi, model_hilo[63:32]);

    push_exp(model(3'd1, 32'h0000_0003, 32'h0000_0004, model_hilo));
    run_op("mult_inj", 3'd1, 32'h0000_0003, 32'h0000_0004, MC, 1'b0, 1);

    move_to("mthi_aa", 3'd5, 32'hAAAA_5555, 1'b0);
    move_to("mtlo_aa", 3'd6, 32'hAAAA_5555, 1'b0);
    push_exp({32'hAAAA_5555, 32'hAAAA_5555});
    run_op("div_zero", 3'd3, 32'h0000_0064, 32'h0000_0000, DC, 1'b0, -1);

    start_E = 1'b1; md_op_E = 3'd3; rs_E = 32'h0000_0064; rt_E = 32'h0000_0007;
    step();
    start_E = 1'b0; md_op_E = 3'd0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    done_n = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) done_n++;
      step();
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    check("abort_hi_after", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
